// File: rtl/tx_pcs_pkg.sv
// tx_pcs_pkg: symbol constants, scheduler state encoding and sizing helper shared by the TX PCS.
package tx_pcs_pkg;
    localparam logic [7:0] K28_5_COM    = 8'hBC;
    localparam logic [7:0] K28_0_SKP    = 8'h1C;
    localparam logic [7:0] LOGICAL_IDLE = 8'h00;

    typedef enum logic [1:0] {IDLE, ALIGN, DATA, SKP} tx_sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/pcs_sym_counter.sv
// pcs_sym_counter: up-counter with synchronous clear and a terminal-count flag against a runtime terminal value.
module pcs_sym_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb cnt_d = clr ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = cnt_q == term;
endmodule

// File: rtl/tx_pcs_scheduler.sv
// tx_pcs_scheduler: feeds the 8b/10b encoder with a COM alignment burst, then MAC symbols
// under valid/ready, with periodic SKP ordered sets and logical idle fill.
module tx_pcs_scheduler
    import tx_pcs_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3,
    parameter int ALIGN_LEN    = 16
) (
    input  logic       Bit_Rate_10,
    input  logic       Rst,
    input  logic       tx_en,
    input  logic [7:0] mac_data,
    input  logic       mac_datak,
    input  logic       mac_valid,
    output logic       mac_ready,
    output logic [7:0] data,
    output logic       TXDataK,
    output logic       enable,
    output logic       align_done
);
    localparam int CW = $clog2(max3(SKP_INTERVAL, ALIGN_LEN, SKP_COUNT + 1));
    localparam logic [CW-1:0] ALIGN_T = CW'(ALIGN_LEN - 1);
    localparam logic [CW-1:0] SKP_T   = CW'(SKP_COUNT);
    localparam logic [CW-1:0] SYM_T   = CW'(SKP_INTERVAL - 1);

    tx_sched_state_t state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            txdatak_q, txdatak_d, enable_q, enable_d, align_done_q, align_done_d;
    logic [CW-1:0]   pos_cnt, sym_cnt_unused;
    logic            pos_tc, sym_tc, skp_due, accept;

    assign skp_due   = state_q == DATA && sym_tc;
    assign mac_ready = tx_en && state_q == DATA && !skp_due;
    assign accept    = mac_valid && mac_ready;

    // One position counter serves both the COM burst and the ordered set; it restarts on every state change.
    pcs_sym_counter #(.W(CW)) u_pos_cnt (
        .clk  (Bit_Rate_10),
        .rst  (Rst),
        .clr  (state_d != state_q || (state_q != ALIGN && state_q != SKP)),
        .term (state_q == ALIGN ? ALIGN_T : SKP_T),
        .cnt  (pos_cnt),
        .tc   (pos_tc)
    );

    pcs_sym_counter #(.W(CW)) u_sym_cnt (
        .clk  (Bit_Rate_10),
        .rst  (Rst),
        .clr  (state_q != DATA || state_d != DATA),
        .term (SYM_T),
        .cnt  (sym_cnt_unused),
        .tc   (sym_tc)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = LOGICAL_IDLE;
        txdatak_d    = 1'b0;
        enable_d     = tx_en && state_q != IDLE;
        align_done_d = tx_en && (state_q == DATA || state_q == SKP);
        if (!tx_en) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:  state_d = ALIGN;
                ALIGN: begin
                    data_d    = K28_5_COM;
                    txdatak_d = 1'b1;
                    state_d   = pos_tc ? DATA : ALIGN;
                end
                DATA: begin
                    data_d    = accept ? mac_data : LOGICAL_IDLE;
                    txdatak_d = accept && mac_datak;
                    state_d   = skp_due ? SKP : DATA;
                end
                SKP: begin
                    data_d    = pos_cnt == '0 ? K28_5_COM : K28_0_SKP;
                    txdatak_d = 1'b1;
                    state_d   = pos_tc ? DATA : SKP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            data_q       <= LOGICAL_IDLE;
            txdatak_q    <= 1'b0;
            enable_q     <= 1'b0;
            align_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            txdatak_q    <= txdatak_d;
            enable_q     <= enable_d;
            align_done_q <= align_done_d;
        end
    end

    assign data       = data_q;
    assign TXDataK    = txdatak_q;
    assign enable     = enable_q;
    assign align_done = align_done_q;
endmodule
